// File: rtl/demux_scan_seq_pkg.sv
// Shared types and sizes for the demux scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_scan_pkg;

    localparam int NCH  = 8;
    localparam int SELW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/demux_scan_seq_if.sv
// Request/data/select bundle between a scan requester and the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start is a level request sampled only while idle.
interface demux_scan_seq_if;
    import demux_scan_pkg::*;

    logic            start;
    logic [NCH-1:0]  mask;
    logic            din;
    logic            i;
    logic            s2;
    logic            s1;
    logic            s0;
    logic            busy;
    logic            done;
    logic [SELW-1:0] ch;

    modport master (
        output start, mask, din,
        input  i, s2, s1, s0, busy, done, ch
    );

    modport slave (
        input  start, mask, din,
        output i, s2, s1, s0, busy, done, ch
    );
endinterface

// File: rtl/demux_scan_seq_next_ch_find.sv
// Finds the next set mask bit above cur_idx (or the lowest set bit when from_none).
// Latency: combinational.
// Backpressure: none.
module next_ch_find
    import demux_scan_pkg::*;
(
    input  logic [NCH-1:0]  mask,
    input  logic [SELW-1:0] cur_idx,
    input  logic            from_none,
    output logic [SELW-1:0] nxt_idx,
    output logic            found
);

    // Ascending priority scan: first enabled channel strictly above the current one.
    always_comb begin
        found   = 1'b0;
        nxt_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && mask[k] && (from_none || (k > int'(cur_idx)))) begin
                found   = 1'b1;
                nxt_idx = SELW'(k);
            end
        end
    end

endmodule

// File: rtl/demux_scan_seq.sv
// Walks enabled demux channels in ascending order, dwelling DWELL cycles on each; DEMUX_SCAN_LOOP_EN enables wrap-around.
// Latency: select/busy one cycle after accepted start; din->i one cycle; done one cycle after last dwell.
// Backpressure: none; start is ignored outside IDLE (except as a wrap request in loop mode).
module demux_scan_seq
    import demux_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    demux_scan_seq_if.slave  bus
);

`ifdef DEMUX_SCAN_LOOP_EN
    localparam logic LOOP_EN = 1'b1;
`else
    localparam logic LOOP_EN = 1'b0;
`endif

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    state_e          state_q, state_d;
    logic [NCH-1:0]  mask_q,  mask_d;
    logic [SELW-1:0] ch_q,    ch_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            i_q,     i_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic [SELW-1:0] nxt_ch;
    logic            nxt_found;
    logic [NCH-1:0]  low_mask;
    logic [SELW-1:0] low_ch;
    logic            low_found;

    // In IDLE the lowest bit must come from the incoming mask; in SCAN (wrap) from the latched copy.
    assign low_mask = (state_q == IDLE) ? bus.mask : mask_q;

    next_ch_find u_next (
        .mask      (mask_q),
        .cur_idx   (ch_q),
        .from_none (1'b0),
        .nxt_idx   (nxt_ch),
        .found     (nxt_found)
    );

    next_ch_find u_low (
        .mask      (low_mask),
        .cur_idx   ('0),
        .from_none (1'b1),
        .nxt_idx   (low_ch),
        .found     (low_found)
    );

    // Next-state and registered-output values; outputs default to their idle values.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        i_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (low_found) begin
                        mask_d  = bus.mask;
                        ch_d    = low_ch;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = SCAN;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            SCAN: begin
                busy_d = 1'b1;
                i_d    = bus.din;
                if (cnt_q == CNT_LAST) begin
                    if (nxt_found) begin
                        ch_d  = nxt_ch;
                        cnt_d = '0;
                    end else if (LOOP_EN && bus.start) begin
                        ch_d  = low_ch;
                        cnt_d = '0;
                    end else begin
                        busy_d  = 1'b0;
                        i_d     = 1'b0;
                        done_d  = 1'b1;
                        ch_d    = '0;
                        cnt_d   = '0;
                        state_d = FIN;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIN: begin
                ch_d    = '0;
                state_d = IDLE;
            end
            default: begin
                ch_d    = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
            i_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.i  = i_q;
    assign bus.s2 = ch_q[2];
    assign bus.s1 = ch_q[1];
    assign bus.s0 = ch_q[0];
    assign bus.ch = ch_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_demux_scan_seq.sv
// Directed bench for demux_scan_seq at DWELL=4, 2 and 1 (loop test when DEMUX_SCAN_LOOP_EN is set).
// Latency: n/a.
// Backpressure: n/a.
module tb_demux_scan_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_r   [3];
    logic       start_r [3];
    logic       din_r   [3];
    logic [7:0] mask_r  [3];

    logic       obs_i    [3];
    logic       obs_busy [3];
    logic       obs_done [3];
    logic [2:0] obs_ch   [3];
    logic [2:0] obs_sel  [3];

    int n_chk  = 0;
    int n_pass = 0;

    demux_scan_seq_if if0 ();
    demux_scan_seq_if if1 ();
    demux_scan_seq_if if2 ();

    assign if0.start = start_r[0];
    assign if0.mask  = mask_r[0];
    assign if0.din   = din_r[0];
    assign if1.start = start_r[1];
    assign if1.mask  = mask_r[1];
    assign if1.din   = din_r[1];
    assign if2.start = start_r[2];
    assign if2.mask  = mask_r[2];
    assign if2.din   = din_r[2];

    assign obs_i[0] = if0.i;  assign obs_busy[0] = if0.busy;  assign obs_done[0] = if0.done;
    assign obs_ch[0] = if0.ch; assign obs_sel[0] = {if0.s2, if0.s1, if0.s0};
    assign obs_i[1] = if1.i;  assign obs_busy[1] = if1.busy;  assign obs_done[1] = if1.done;
    assign obs_ch[1] = if1.ch; assign obs_sel[1] = {if1.s2, if1.s1, if1.s0};
    assign obs_i[2] = if2.i;  assign obs_busy[2] = if2.busy;  assign obs_done[2] = if2.done;
    assign obs_ch[2] = if2.ch; assign obs_sel[2] = {if2.s2, if2.s1, if2.s0};

    demux_scan_seq #(.DWELL(4), .CW(8)) u_d4 (.clk(clk), .rst_n(rst_r[0]), .bus(if0.slave));
    demux_scan_seq #(.DWELL(2), .CW(8)) u_d2 (.clk(clk), .rst_n(rst_r[1]), .bus(if1.slave));
    demux_scan_seq #(.DWELL(1), .CW(8)) u_d1 (.clk(clk), .rst_n(rst_r[2]), .bus(if2.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int d, input string tag, input logic exp_done);
        check({tag, ".done"}, 32'(obs_done[d]), 32'(exp_done));
        check({tag, ".busy"}, 32'(obs_busy[d]), 32'd0);
        check({tag, ".ch"},   32'(obs_ch[d]),   32'd0);
        check({tag, ".sel"},  32'(obs_sel[d]),  32'd0);
        check({tag, ".i"},    32'(obs_i[d]),    32'd0);
    endtask

    // One scan: din during cycle c (c=-1 is the accept cycle) is dpat[(c+1)%8].
    task automatic scan(input int d, input int dwell, input logic [7:0] m,
                        input logic [7:0] dpat, input int restart_at, input string tag);
        int         list[$];
        int         c;
        logic       iexp;
        logic [2:0] ch_e;
        logic [7:0] y_got, y_exp;
        for (int k = 0; k < 8; k++)
            if (m[k]) list.push_back(k);
        start_r[d] = 1'b1;
        mask_r[d]  = m;
        din_r[d]   = dpat[0];
        step();
        start_r[d] = 1'b0;
        mask_r[d]  = ~m;
        if (list.size() == 0) begin
            check_idle(d, {tag, ".pulse"}, 1'b1);
            step();
            check_idle(d, {tag, ".after"}, 1'b0);
            return;
        end
        c = 0;
        for (int j = 0; j < list.size(); j++) begin
            for (int t = 0; t < dwell; t++) begin
                ch_e = 3'(list[j]);
                iexp = (c == 0) ? 1'b0 : dpat[c % 8];
                check({tag, ".busy"}, 32'(obs_busy[d]), 32'd1);
                check({tag, ".done"}, 32'(obs_done[d]), 32'd0);
                check({tag, ".ch"},   32'(obs_ch[d]),   32'(ch_e));
                check({tag, ".sel"},  32'(obs_sel[d]),  32'(ch_e));
                check({tag, ".i"},    32'(obs_i[d]),    32'(iexp));
                y_got = obs_i[d] ? (8'd1 << obs_ch[d]) : 8'd0;
                y_exp = iexp ? (8'd1 << ch_e) : 8'd0;
                check({tag, ".y"}, 32'(y_got), 32'(y_exp));
                din_r[d]   = dpat[(c + 1) % 8];
                start_r[d] = (c == restart_at);
                step();
                c++;
            end
        end
        start_r[d] = 1'b0;
        check_idle(d, {tag, ".fin"}, 1'b1);
        step();
        check_idle(d, {tag, ".post"}, 1'b0);
        step();
        check_idle(d, {tag, ".post2"}, 1'b0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_r[d]   = 1'b0;
            start_r[d] = 1'b0;
            din_r[d]   = 1'b1;
            mask_r[d]  = 8'hFF;
        end
        step();
        step();
        for (int d = 0; d < 3; d++) check_idle(d, "rst", 1'b0);
        for (int d = 0; d < 3; d++) rst_r[d] = 1'b1;
        step();

        scan(0, 4, 8'hFF, 8'hFF, -1, "full");
        scan(1, 2, 8'b1010_0100, 8'b0110_1001, -1, "sparse");
        scan(1, 2, 8'h00, 8'hFF, -1, "empty");
        scan(0, 4, 8'b0001_0110, 8'hA5, 5, "restart");
        scan(2, 1, 8'h81, 8'h3C, -1, "dw1");

        // Reset while channel 3 is selected: everything clears, no done follows.
        start_r[0] = 1'b1;
        mask_r[0]  = 8'hFF;
        din_r[0]   = 1'b1;
        step();
        start_r[0] = 1'b0;
        for (int c = 0; c < 12; c++) step();
        check("mid.ch", 32'(obs_ch[0]), 32'd3);
        rst_r[0] = 1'b0;
        step();
        check_idle(0, "mid.rst", 1'b0);
        rst_r[0] = 1'b1;
        step();
        check_idle(0, "mid.rel", 1'b0);
        step();
        check_idle(0, "mid.rel2", 1'b0);
        scan(0, 4, 8'h00, 8'hFF, -1, "mid.empty");

`ifdef DEMUX_SCAN_LOOP_EN
        start_r[2] = 1'b1;
        mask_r[2]  = 8'h81;
        din_r[2]   = 1'b1;
        step();
        for (int c = 0; c < 6; c++) begin
            check("loop.busy", 32'(obs_busy[2]), 32'd1);
            check("loop.done", 32'(obs_done[2]), 32'd0);
            check("loop.ch",   32'(obs_ch[2]),   (c % 2 == 1) ? 32'd7 : 32'd0);
            step();
        end
        check("loop.ch6", 32'(obs_ch[2]), 32'd0);
        start_r[2] = 1'b0;
        step();
        check("loop.ch7", 32'(obs_ch[2]), 32'd7);
        check("loop.busy7", 32'(obs_busy[2]), 32'd1);
        step();
        check_idle(2, "loop.fin", 1'b1);
        step();
        check_idle(2, "loop.post", 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
